// File: rtl/tcm_mem_pkg.sv
// Shared geometry and types for the TCM backing RAM.
package tcm_mem_pkg;
   localparam int TCM_ADDR_W = 11;
   localparam int TCM_DATA_W = 64;
   localparam int TCM_BE_W   = TCM_DATA_W / 8;

   typedef logic [TCM_ADDR_W-1:0] tcm_addr_t;
   typedef logic [TCM_DATA_W-1:0] tcm_data_t;
   typedef logic [TCM_BE_W-1:0]   tcm_be_t;
endpackage

// File: rtl/blk_mem_lane.sv
// One 8-bit byte lane of the TCM RAM: true dual-port, read-first, port B wins on collision.
module blk_mem_lane #(
   parameter int ADDR_W = 11
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [7:0]        dina,
   output logic [7:0]        douta,
   input  logic              web,
   input  logic [ADDR_W-1:0] addrb,
   input  logic [7:0]        dinb,
   output logic [7:0]        doutb
);
   localparam int DEPTH = 2**ADDR_W;

   logic [7:0] r_mem [DEPTH] = '{default: 8'h00};
   logic [7:0] r_douta = 8'h00;
   logic [7:0] r_doutb = 8'h00;

   // Both ports in one process: the later port-B write overrides port A on a shared address,
   // and non-blocking reads see the contents from before this edge's writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_douta <= 8'h00;
         r_doutb <= 8'h00;
      end else begin
         r_douta <= r_mem[addra];
         r_doutb <= r_mem[addrb];
      end
      if (wea) r_mem[addra] <= dina;
      if (web) r_mem[addrb] <= dinb;
   end

   assign douta = r_douta;
   assign doutb = r_doutb;
endmodule

// File: rtl/blk_mem_gen.sv
// 2048 x 64 true dual-port TCM RAM with byte write enables, built from byte lanes.
module blk_mem_gen
   import tcm_mem_pkg::*;
#(
   parameter int ADDR_W = TCM_ADDR_W,
   parameter int DATA_W = TCM_DATA_W,
   parameter int BE_W   = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [BE_W-1:0]   wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   output logic [DATA_W-1:0] douta,
   input  logic [BE_W-1:0]   web,
   input  logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] dinb,
   output logic [DATA_W-1:0] doutb
);
   for (genvar n = 0; n < BE_W; n++) begin : g_lane
      blk_mem_lane #(
         .ADDR_W(ADDR_W)
      ) u_lane (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .wea   (wea[n]),
         .addra (addra),
         .dina  (dina[8*n +: 8]),
         .douta (douta[8*n +: 8]),
         .web   (web[n]),
         .addrb (addrb),
         .dinb  (dinb[8*n +: 8]),
         .doutb (doutb[8*n +: 8])
      );
   end
endmodule

// File: tb/tb_blk_mem_gen.sv
// Directed bench for blk_mem_gen: reset, latency, byte masks, read-first and collisions.
module tb_blk_mem_gen;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [7:0]  wea, web;
   logic [10:0] addra, addrb;
   logic [63:0] dina, dinb;
   logic [63:0] douta, doutb;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   blk_mem_gen dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta),
      .web   (web),
      .addrb (addrb),
      .dinb  (dinb),
      .doutb (doutb)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      wea = '0; web = '0;
      addra = '0; addrb = '0;
      dina = '0; dinb = '0;

      // Reset held for two cycles.
      tick(); tick();
      check("rst_douta", douta, 64'h0);
      check("rst_doutb", doutb, 64'h0);

      // Full write then latency check.
      rst_i = 1'b0;
      wea = 8'hFF; addra = 11'h005; dina = 64'h1122334455667788;
      tick();
      wea = '0; addra = 11'h000;
      tick();
      check("lat_other_addr", douta, 64'h0);
      addra = 11'h005;
      check("lat_before_edge", douta, 64'h0);
      tick();
      check("lat_after_edge", douta, 64'h1122334455667788);

      // Byte masking via port B.
      wea = 8'hFF; addra = 11'h010; dina = 64'hFFFFFFFFFFFFFFFF;
      tick();
      wea = '0;
      web = 8'h0F; addrb = 11'h010; dinb = 64'h0;
      tick();
      web = '0;
      tick();
      check("byte_mask", doutb, 64'hFFFFFFFF00000000);

      // Read-first on the same port.
      wea = 8'hFF; addra = 11'h020; dina = 64'hAAAAAAAAAAAAAAAA;
      tick();
      dina = 64'h5555555555555555;
      tick();
      check("rf_old", douta, 64'hAAAAAAAAAAAAAAAA);
      wea = '0;
      tick();
      check("rf_new", douta, 64'h5555555555555555);

      // Cross-port read of an address being written.
      wea = 8'hFF; addra = 11'h100; dina = 64'hDEADBEEFCAFEF00D;
      addrb = 11'h100;
      tick();
      check("xport_old", doutb, 64'h0);
      wea = '0;
      tick();
      check("xport_new", doutb, 64'hDEADBEEFCAFEF00D);

      // Write-write collision at the top address.
      wea = 8'hFF; addra = 11'h7FF; dina = 64'h1111111111111111;
      web = 8'hF0; addrb = 11'h7FF; dinb = 64'h2222222222222222;
      tick();
      wea = '0; web = '0;
      tick();
      check("coll_a", douta, 64'h2222222211111111);
      check("coll_b", doutb, 64'h2222222211111111);

      // Reset mid-operation with a write in flight.
      rst_i = 1'b1;
      wea = 8'hFF; addra = 11'h3A0; dina = 64'h0123456789ABCDEF;
      addrb = 11'h005;
      tick();
      check("midrst_douta", douta, 64'h0);
      check("midrst_doutb", doutb, 64'h0);
      wea = '0;
      tick();
      check("midrst_hold", douta, 64'h0);
      rst_i = 1'b0;
      tick();
      check("post_rst_3a0", douta, 64'h0123456789ABCDEF);
      check("post_rst_005", doutb, 64'h1122334455667788);
      addra = 11'h7FF; addrb = 11'h010;
      tick();
      check("intact_7ff", douta, 64'h2222222211111111);
      check("intact_010", doutb, 64'hFFFFFFFF00000000);
      addra = 11'h100; addrb = 11'h020;
      tick();
      check("intact_100", douta, 64'hDEADBEEFCAFEF00D);
      check("intact_020", doutb, 64'h5555555555555555);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/blk_mem_gen.md
Name: blk_mem_gen

Overview:
- True dual-port synchronous RAM backing the TCM.
- Geometry: 2048 words x 64 bits (16 KB), per-byte write enables on both ports, read-first semantics, one-cycle registered read latency.
- Sits under the TCM wrapper: port A serves the instruction/data side, port B the second requester.
- Both ports run on a single shared clock.

Parameters:
- ADDR_W, 11, word address width; depth = 2**ADDR_W words.
- DATA_W, 64, word width in bits; must be a multiple of 8.
- BE_W, DATA_W/8 = 8, number of byte-enable bits per port.

Ports:
- clk_i  in  1  single clock for both ports, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wea  in  BE_W  port A byte write enables; bit n covers dina[8n+7:8n].
- addra  in  ADDR_W  port A word address.
- dina  in  DATA_W  port A write data.
- douta  out  DATA_W  port A registered read data.
- web  in  BE_W  port B byte write enables.
- addrb  in  ADDR_W  port B word address.
- dinb  in  DATA_W  port B write data.
- doutb  out  DATA_W  port B registered read data.

Behaviour:
- No enable inputs: both ports read every cycle; a write happens only when an enable bit is set.
- Read timing: douta/doutb load mem[addr] on each rising edge, so data is valid 1 cycle after the address is presented, then held until the next edge.
- Read-first: a port writing address X returns X's contents from before that edge's write. The new data is visible one cycle later, provided the same address is still applied.
- Byte writes: on a rising edge, for each n with wea[n]=1, mem[addra] byte n <= dina byte n. Bytes whose enable is 0 are unchanged. Port B is identical with web/addrb/dinb.
- wea=0 and web=0 are pure reads.
- Cross-port read of an address being written by the other port in the same cycle also returns the old data (read-first on both ports).
- Write collision (both ports write the same address in the same cycle):
  - Bytes enabled on only one port take that port's data.
  - Bytes enabled on both ports take port B's data (port B wins).
  - The collision is deterministic and is not flagged.
- Reset:
  - While rst_i=1 at a rising edge, douta and doutb are forced to 0.
  - Memory contents are not cleared by reset.
  - Writes presented during reset are still performed.
  - The first read after rst_i falls returns valid data one cycle later.
  - Reset asserted mid-operation only zeroes the output registers; no data is lost.
- Power-up: memory and output registers initialise to 0 in simulation. No initial-value file.
- Addresses are full-range: all 2048 words are valid, with no wrap or out-of-range handling.
- Synthesis: infer one true-dual-port block RAM with byte-write. Code both ports in a single clocked process so the collision priority is explicit.

Decomposition:
- Shared package tcm_mem_pkg holds:
  - constants TCM_ADDR_W = 11, TCM_DATA_W = 64, TCM_BE_W = 8;
  - typedefs tcm_addr_t, tcm_data_t, tcm_be_t.
- One natural sub-module, blk_mem_lane: 8-bit x depth dual-port byte lane with per-port write enable, read-first, and port-B priority.
  - blk_mem_gen instantiates BE_W lanes and concatenates their outputs.
  - The output reset lives in the lane.

Test Plan:
- Reset and read-latency:
  - Hold rst_i=1 for 2 cycles -> douta = doutb = 0.
  - Release; write A addr 0x005 = 0x1122334455667788 with wea=0xFF.
  - Read A at 0x005 -> the value appears exactly 1 cycle after the address is applied.
- Byte masking:
  - Preload addr 0x010 = 0xFFFFFFFFFFFFFFFF.
  - Write B dinb = 0, web = 0x0F -> read at 0x010 returns 0xFFFFFFFF00000000.
- Read-first same port:
  - addr 0x020 holds 0xAAAA...; write A 0x5555... to 0x020 with wea=0xFF.
  - douta that cycle = 0xAAAA...; next cycle = 0x5555....
- Cross-port collision read:
  - A writes 0xDEADBEEFCAFEF00D to 0x100 while B reads 0x100 (old value 0).
  - doutb = 0 that cycle, 0xDEADBEEFCAFEF00D the next.
- Write-write collision:
  - A: wea=0xFF, dina=0x1111111111111111; B: web=0xF0, dinb=0x2222222222222222; both at 0x7FF (top address).
  - Readback = 0x2222222211111111.
- Reset mid-operation:
  - Write 0x0123456789ABCDEF to 0x3A0 with rst_i=1 -> outputs stay 0.
  - After reset, read 0x3A0 returns 0x0123456789ABCDEF; other preloaded words are intact.
